// File: rtl/bcd_cnt_pkg.sv
// Shared types and helpers for the multi-digit BCD up/down counter.
package bcd_cnt_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    localparam bcd_digit_t DIGIT_MAX = 4'd9;
    localparam bcd_digit_t DIGIT_MIN = 4'd0;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    function automatic logic is_valid_bcd(input bcd_digit_t digit);
        return digit <= DIGIT_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade cell: steps by one in either direction when step_in is high,
// and passes the carry/borrow on through step_out.
module bcd_digit
    import bcd_cnt_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  bcd_digit_t rst_val,
    input  logic       step_in,
    input  logic       up_dn,
    input  logic       ld,
    input  bcd_digit_t ld_val,
    output bcd_digit_t q,
    output logic       step_out
);

    dir_e dir;

    assign dir      = dir_e'(up_dn);
    assign step_out = step_in & ((dir == DIR_UP) ? (q == DIGIT_MAX) : (q == DIGIT_MIN));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= rst_val;
        end else if (ld) begin
            q <= ld_val;
        end else if (step_in) begin
            if (dir == DIR_UP)
                q <= (q == DIGIT_MAX) ? DIGIT_MIN : q + 4'd1;
            else
                q <= (q == DIGIT_MIN) ? DIGIT_MAX : q - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// NUM_DIGITS-decade BCD up/down counter with validated load, tc, wrap and load_err.
// Define BCD_CNT_SATURATE_EN to hold at all-9s/all-0s instead of wrapping.
module bcd_updown_counter
    import bcd_cnt_pkg::*;
#(
    parameter int unsigned                  NUM_DIGITS = 4,
    parameter logic [4*NUM_DIGITS-1:0]      RESET_VAL  = '0
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    tc,
    output logic                    wrap,
    output logic                    load_err
);

    logic [NUM_DIGITS-1:0] step_in;
    logic [NUM_DIGITS-1:0] step_out;
    logic                  load_ok;
    logic                  all_max;
    logic                  all_min;
    logic                  term;
    logic                  ld;

    always_comb begin
        load_ok = 1'b1;
        all_max = 1'b1;
        all_min = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            load_ok = load_ok & is_valid_bcd(load_val[DIGIT_W*i +: DIGIT_W]);
            all_max = all_max & (count[DIGIT_W*i +: DIGIT_W] == DIGIT_MAX);
            all_min = all_min & (count[DIGIT_W*i +: DIGIT_W] == DIGIT_MIN);
        end
    end

    assign term = up_dn ? all_max : all_min;
    assign tc   = en & ~load & term;
    assign ld   = load & load_ok;

`ifdef BCD_CNT_SATURATE_EN
    // Suppressing the first step at the terminal value freezes the whole chain.
    assign step_in[0] = en & ~load & ~term;
`else
    assign step_in[0] = en & ~load;
`endif

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        if (i > 0) begin : g_chain
            assign step_in[i] = step_out[i-1];
        end
        bcd_digit u_digit (
            .clk     (clk),
            .clr     (clr),
            .rst_val (RESET_VAL[DIGIT_W*i +: DIGIT_W]),
            .step_in (step_in[i]),
            .up_dn   (up_dn),
            .ld      (ld),
            .ld_val  (load_val[DIGIT_W*i +: DIGIT_W]),
            .q       (count[DIGIT_W*i +: DIGIT_W]),
            .step_out(step_out[i])
        );
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
`ifdef BCD_CNT_SATURATE_EN
            wrap     <= 1'b0;
`else
            // Carry out of the top digit is exactly the all-9s/all-0s rollover.
            wrap     <= step_out[NUM_DIGITS-1];
`endif
            load_err <= load & ~load_ok;
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Randomized self-checking bench for bcd_updown_counter against an integer model.
module tb_bcd_updown_counter;

    localparam int unsigned ND   = 2;
    localparam int unsigned W    = 4 * ND;
    localparam int          MAXV = 99;
    localparam logic [W-1:0] RSTV = 8'h00;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic         en = 1'b0;
    logic         up_dn = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] count;
    logic         tc;
    logic         wrap;
    logic         load_err;

    int ntests = 0;
    int nfail  = 0;

    int mval;
    bit mwrap;
    bit merr;

    bcd_updown_counter #(
        .NUM_DIGITS(ND),
        .RESET_VAL (RSTV)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .en      (en),
        .up_dn   (up_dn),
        .load    (load),
        .load_val(load_val),
        .count   (count),
        .tc      (tc),
        .wrap    (wrap),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < int'(ND); i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Returns -1 when any nibble is not a decimal digit.
    function automatic int from_bcd(input logic [W-1:0] b);
        int v;
        int scale;
        int d;
        v = 0;
        scale = 1;
        for (int i = 0; i < int'(ND); i++) begin
            d = int'(b[4*i +: 4]);
            if (d > 9) return -1;
            v += d * scale;
            scale *= 10;
        end
        return v;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".count"}, 32'(count), 32'(to_bcd(mval)));
        check({tag, ".wrap"}, 32'(wrap), 32'(mwrap));
        check({tag, ".load_err"}, 32'(load_err), 32'(merr));
    endtask

    // Drive one cycle of inputs, check tc before the edge and registered outputs after.
    task automatic step(input string tag, input logic e, input logic u,
                        input logic l, input logic [W-1:0] lv);
        int dec;
        bit exp_tc;
        en = e;
        up_dn = u;
        load = l;
        load_val = lv;
        #1;
        exp_tc = e && !l && (u ? (mval == MAXV) : (mval == 0));
        check({tag, ".tc"}, 32'(tc), 32'(exp_tc));
        @(posedge clk);
        mwrap = 1'b0;
        merr  = 1'b0;
        if (l) begin
            dec = from_bcd(lv);
            if (dec < 0) merr = 1'b1;
            else mval = dec;
        end else if (e) begin
            if (u) begin
                if (mval == MAXV) begin
`ifndef BCD_CNT_SATURATE_EN
                    mval = 0;
                    mwrap = 1'b1;
`endif
                end else begin
                    mval++;
                end
            end else begin
                if (mval == 0) begin
`ifndef BCD_CNT_SATURATE_EN
                    mval = MAXV;
                    mwrap = 1'b1;
`endif
                end else begin
                    mval--;
                end
            end
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic reset_model();
        mval  = from_bcd(RSTV);
        mwrap = 1'b0;
        merr  = 1'b0;
    endtask

    initial begin
        logic [W-1:0] lv;
        reset_model();
        #2;
        check_outputs("reset");
        @(posedge clk);
        #2;
        clr = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("post_reset");

        step("ld09", 1, 1, 1, 8'h09);
        step("up09", 1, 1, 0, 8'h00);
        step("ld99", 0, 1, 1, 8'h99);
        step("wrap_up", 1, 1, 0, 8'h00);
        step("wrap_clear", 0, 1, 0, 8'h00);
        step("ld10", 0, 0, 1, 8'h10);
        step("dn1", 1, 0, 0, 8'h00);
        step("dn2", 1, 0, 0, 8'h00);
        step("ld00", 0, 0, 1, 8'h00);
        step("wrap_dn", 1, 0, 0, 8'h00);
        step("ld25", 0, 1, 1, 8'h25);
        step("bad_ld_en", 1, 1, 1, 8'h3A);
        step("bad_ld_after", 0, 1, 0, 8'h00);
        step("bad_ld_noen", 0, 1, 1, 8'h3A);
        step("bad_ld_after2", 0, 1, 0, 8'h00);
        step("ld55_en", 1, 1, 1, 8'h55);
        step("ld50", 0, 1, 1, 8'h50);
        step("flip_dn", 1, 0, 0, 8'h00);
        step("ld47", 0, 1, 1, 8'h47);
        step("up47", 1, 1, 0, 8'h00);

        // Reset in the middle of a cycle with en and load both active.
        en = 1'b1;
        load = 1'b1;
        load_val = 8'h33;
        clr = 1'b1;
        #1;
        reset_model();
        check_outputs("clr_async");
        @(posedge clk);
        #1;
        check_outputs("clr_held");
        clr = 1'b0;

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(1, 0) == 1) begin
                lv = W'($urandom);
            end else begin
                for (int i = 0; i < int'(ND); i++) lv[4*i +: 4] = 4'($urandom_range(9, 0));
            end
            step("rand", ($urandom_range(3, 0) != 0), 1'($urandom), ($urandom_range(9, 0) == 0), lv);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
